// File: rtl/mac_acc_seq.sv
// Sequencer around an external combinational 32x32+64 MAC: accumulates a dot product
// beat by beat and presents the 64-bit sum with a sticky carry flag and a beat count.
module mac_acc_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a_in,
    input  logic [31:0]      b_in,
    input  logic             in_last,
    output logic [31:0]      mac_multiplicand,
    output logic [31:0]      mac_multiplier,
    output logic [63:0]      mac_acc_in,
    input  logic [64:0]      mac_acc_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             res_ovf,
    output logic [CNT_W-1:0] res_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       r_state;
    logic [63:0]      r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;

    logic w_accept;
    logic w_release;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign mac_multiplicand = a_in;
    assign mac_multiplier   = b_in;
    assign mac_acc_in       = r_acc;

    assign in_ready  = (r_state != S_HOLD);
    assign res_valid = (r_state == S_HOLD);
    assign res_data  = r_acc;
    assign res_ovf   = r_ovf;
    assign res_count = r_count;

    // HOLD never accepts a beat, so a release and an accept can never coincide.
    assign w_accept  = in_valid & in_ready;
    assign w_release = (r_state == S_HOLD) & res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_release) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_state <= in_last ? S_HOLD : S_ACCUM;
            r_acc   <= mac_acc_out[63:0];
            r_ovf   <= r_ovf | mac_acc_out[64];
            r_count <= sat_inc(r_count);
        end
    end

endmodule

// File: tb/tb_mac_acc_seq.sv
// Self-checking bench for mac_acc_seq; models the external MAC and compares results
// against an exact wide-integer sum of products.
module tb_mac_acc_seq;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a_in;
    logic [31:0]      b_in;
    logic             in_last;
    logic [31:0]      mac_multiplicand;
    logic [31:0]      mac_multiplier;
    logic [63:0]      mac_acc_in;
    logic [64:0]      mac_acc_out;
    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_data;
    logic             res_ovf;
    logic [CNT_W-1:0] res_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // External MAC: product plus accumulator, 65-bit result.
    assign mac_acc_out = 65'(mac_multiplicand) * 65'(mac_multiplier) + 65'(mac_acc_in);

    mac_acc_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .in_last(in_last),
        .mac_multiplicand(mac_multiplicand), .mac_multiplier(mac_multiplier),
        .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ovf(res_ovf), .res_count(res_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        int waited = 0;
        in_valid = 1'b1; a_in = a; b_in = b; in_last = last;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL beat_accept_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_last = 1'b0;
        a_in = 32'hA5A5A5A5; b_in = 32'h5A5A5A5A;
        step(); step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (res_data !== 64'd0) begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        checks++; if (res_count !== '0) begin errors++; $display("FAIL reset_res_count: got %0d want 0", res_count); end
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL reset_res_ovf: got %0b want 0", res_ovf); end
        checks++; if (mac_acc_in !== 64'd0) begin errors++; $display("FAIL reset_mac_acc_in: got %h want 0", mac_acc_in); end
        checks++; if (mac_multiplicand !== 32'hA5A5A5A5) begin errors++; $display("FAIL passthru_a: got %h want a5a5a5a5", mac_multiplicand); end
        checks++; if (mac_multiplier !== 32'h5A5A5A5A) begin errors++; $display("FAIL passthru_b: got %h want 5a5a5a5a", mac_multiplier); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive_beat(32'h12345678, 32'h87654321, 1'b1);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", res_valid); end
        checks++; if (res_data !== 64'h09A0CD0570B88D78) begin errors++; $display("FAIL single_data: got %h want 09a0cd0570b88d78", res_data); end
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %0b want 0", res_ovf); end
        checks++; if (res_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", res_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready: got %0b want 0", in_ready); end
        res_ready = 1'b1; step(); res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_release_valid: got %0b want 0", res_valid); end
        checks++; if (res_data !== 64'd0) begin errors++; $display("FAIL single_release_data: got %h want 0", res_data); end
        checks++; if (res_count !== 16'd0) begin errors++; $display("FAIL single_release_count: got %0d want 0", res_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_release_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_two_beats();
        drive_beat(32'h11111111, 32'h11111111, 1'b0);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL two_mid_valid: got %0b want 0", res_valid); end
        checks++; if (res_count !== 16'd1) begin errors++; $display("FAIL two_mid_count: got %0d want 1", res_count); end
        checks++; if (res_data !== 64'h0123456787654321) begin errors++; $display("FAIL two_mid_data: got %h want 0123456787654321", res_data); end
        drive_beat(32'd2, 32'd3, 1'b1);
        checks++; if (res_data !== 64'h0123456787654327) begin errors++; $display("FAIL two_data: got %h want 0123456787654327", res_data); end
        checks++; if (res_count !== 16'd2) begin errors++; $display("FAIL two_count: got %0d want 2", res_count); end
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL two_ovf: got %0b want 0", res_ovf); end
        res_ready = 1'b1; step(); res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL two_release: got %0b want 0", res_valid); end
    endtask

    task automatic test_overflow();
        drive_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL ovf_first_beat: got %0b want 0", res_ovf); end
        drive_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        checks++; if (res_data !== 64'hFFFFFFFC00000002) begin errors++; $display("FAIL ovf_data: got %h want fffffffc00000002", res_data); end
        checks++; if (res_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", res_ovf); end
        checks++; if (res_count !== 16'd2) begin errors++; $display("FAIL ovf_count: got %0d want 2", res_count); end
        res_ready = 1'b1; step(); res_ready = 1'b0;
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %0b want 0", res_ovf); end
    endtask

    task automatic test_backpressure();
        drive_beat(32'd5, 32'd7, 1'b1);
        in_valid = 1'b1; a_in = 32'd3; b_in = 32'd4; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
            checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, res_valid); end
            checks++; if (res_data !== 64'd35 || res_count !== 16'd1) begin
                errors++; $display("FAIL bp_stable[%0d]: got data %0d count %0d want 35/1", i, res_data, res_count);
            end
            step();
        end
        res_ready = 1'b1; step(); res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid: got %0b want 0", res_valid); end
        checks++; if (res_count !== 16'd0 || res_data !== 64'd0) begin
            errors++; $display("FAIL bp_beat_taken_early: got data %0d count %0d want 0/0", res_data, res_count);
        end
        step(); in_valid = 1'b0;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_held_beat_valid: got %0b want 1", res_valid); end
        checks++; if (res_data !== 64'd12 || res_count !== 16'd1) begin
            errors++; $display("FAIL bp_held_beat: got data %0d count %0d want 12/1", res_data, res_count);
        end
        res_ready = 1'b1; step(); res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive_beat(32'd9, 32'd9, 1'b0);
        checks++; if (res_data !== 64'd81 || res_count !== 16'd1) begin
            errors++; $display("FAIL mid_live: got data %0d count %0d want 81/1", res_data, res_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (res_data !== 64'd0 || res_count !== 16'd0) begin
            errors++; $display("FAIL mid_async_clear: got data %0d count %0d want 0/0", res_data, res_count);
        end
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_async_ctrl: got valid %0b ready %0b want 0/1", res_valid, in_ready);
        end
        in_valid = 1'b1; a_in = 32'd2; b_in = 32'd3; in_last = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(); in_valid = 1'b0;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL mid_first_edge_accept: got %0b want 1", res_valid); end
        checks++; if (res_data !== 64'd6 || res_count !== 16'd1) begin
            errors++; $display("FAIL mid_after_reset: got data %0d count %0d want 6/1", res_data, res_count);
        end
        res_ready = 1'b1; step(); res_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] sum;
        logic [31:0]  a, b;
        int           n;
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 8);
            sum = '0;
            for (int i = 0; i < n; i++) begin
                a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                repeat ($urandom_range(0, 2)) step();
                drive_beat(a, b, i == n - 1);
                sum = sum + 128'(a) * 128'(b);
                if (i != n - 1) begin
                    checks++; if (res_valid !== 1'b0 || res_count !== 16'(i + 1) || res_data !== sum[63:0]) begin
                        errors++; $display("FAIL rand_live t%0d b%0d: got v%0b c%0d d%h want v0 c%0d d%h",
                                           t, i, res_valid, res_count, res_data, i + 1, sum[63:0]);
                    end
                end
            end
            repeat ($urandom_range(0, 3)) begin
                step();
                checks++; if (res_valid !== 1'b1 || res_data !== sum[63:0]) begin
                    errors++; $display("FAIL rand_hold t%0d: got v%0b d%h want v1 d%h", t, res_valid, res_data, sum[63:0]);
                end
            end
            checks++; if (res_valid !== 1'b1 || res_data !== sum[63:0] || res_count !== 16'(n)
                          || res_ovf !== (sum[127:64] != 0)) begin
                errors++; $display("FAIL rand_result t%0d: got v%0b d%h c%0d o%0b want v1 d%h c%0d o%0b",
                                   t, res_valid, res_data, res_count, res_ovf, sum[63:0], n, sum[127:64] != 0);
            end
            res_ready = 1'b1; step(); res_ready = 1'b0;
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rand_release t%0d: got %0b want 0", t, res_valid); end
        end
    endtask

    task automatic test_count_saturate();
        in_valid = 1'b1; a_in = 32'd0; b_in = 32'd0; in_last = 1'b0;
        repeat (65535) step();
        checks++; if (res_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %0d want 65535", res_count); end
        step();
        checks++; if (res_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %0d want 65535", res_count); end
        in_last = 1'b1;
        step(); in_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_last: got v%0b c%0d want v1 c65535", res_valid, res_count);
        end
        res_ready = 1'b1; step(); res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_beats();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_count_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
